// File: rtl/axi_rr_mux4.sv
// 4:1 AXI4-Stream packet mux with round-robin arbitration between whole packets.
// Output is registered through a 2-entry skid buffer (main + spare).
//
// state | meaning
// IDLE  | no grant held; pick next requester circularly after last_grant
// BUSY  | forwarding beats of one packet from input `grant` until its TLAST
module axi_rr_mux4 #(
    parameter int         C_AXIS_DATA_WIDTH = 64,
    parameter logic [3:0] C_ACTIVE_MASK     = 4'b0011
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA0,
    input  logic                         S_AXIS_TVALID0,
    input  logic                         S_AXIS_TLAST0,
    output logic                         S_AXIS_TREADY0,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA1,
    input  logic                         S_AXIS_TVALID1,
    input  logic                         S_AXIS_TLAST1,
    output logic                         S_AXIS_TREADY1,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA2,
    input  logic                         S_AXIS_TVALID2,
    input  logic                         S_AXIS_TLAST2,
    output logic                         S_AXIS_TREADY2,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA3,
    input  logic                         S_AXIS_TVALID3,
    input  logic                         S_AXIS_TLAST3,
    output logic                         S_AXIS_TREADY3,
    output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    output logic                         M_AXIS_TLAST,
    input  logic                         M_AXIS_TREADY,
    output logic [1:0]                   M_AXIS_TSRC
);

    localparam int W = C_AXIS_DATA_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state, state_nxt;
    logic [1:0]   grant, grant_nxt;
    logic [1:0]   last_grant, last_grant_nxt;

    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [3:0]   req;
    logic [1:0]   pick;
    logic [1:0]   idx;
    logic         found;

    logic [W-1:0] sel_data;
    logic         sel_last;
    logic         in_acc;
    logic         skid_ready;

    logic [W-1:0] m_data, sp_data;
    logic         m_valid, m_last, sp_valid, sp_last;
    logic [1:0]   m_src, sp_src;

    assign s_valid = {S_AXIS_TVALID3, S_AXIS_TVALID2, S_AXIS_TVALID1, S_AXIS_TVALID0};
    assign req     = s_valid & C_ACTIVE_MASK;

    // First requester strictly after last_grant, wrapping around.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = S_AXIS_TDATA0;
        sel_last = S_AXIS_TLAST0;
        case (grant)
            2'd0: begin sel_data = S_AXIS_TDATA0; sel_last = S_AXIS_TLAST0; end
            2'd1: begin sel_data = S_AXIS_TDATA1; sel_last = S_AXIS_TLAST1; end
            2'd2: begin sel_data = S_AXIS_TDATA2; sel_last = S_AXIS_TLAST2; end
            default: begin sel_data = S_AXIS_TDATA3; sel_last = S_AXIS_TLAST3; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        s_ready        = 4'b0000;
        in_acc         = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                s_ready[grant] = skid_ready;
                in_acc         = s_valid[grant] & skid_ready;
                if (in_acc && sel_last) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign S_AXIS_TREADY0 = s_ready[0] & C_ACTIVE_MASK[0];
    assign S_AXIS_TREADY1 = s_ready[1] & C_ACTIVE_MASK[1];
    assign S_AXIS_TREADY2 = s_ready[2] & C_ACTIVE_MASK[2];
    assign S_AXIS_TREADY3 = s_ready[3] & C_ACTIVE_MASK[3];

    // Spare only fills while main is stalled, so spare-empty alone gates intake.
    assign skid_ready = ~sp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_src    <= 2'd0;
            m_data   <= '0;
            sp_valid <= 1'b0;
            sp_last  <= 1'b0;
            sp_src   <= 2'd0;
            sp_data  <= '0;
        end else if (!m_valid || M_AXIS_TREADY) begin
            if (sp_valid) begin
                m_valid  <= 1'b1;
                m_data   <= sp_data;
                m_last   <= sp_last;
                m_src    <= sp_src;
                sp_valid <= 1'b0;
            end else begin
                m_valid <= in_acc;
                if (in_acc) begin
                    m_data <= sel_data;
                    m_last <= sel_last;
                    m_src  <= grant;
                end
            end
        end else if (in_acc) begin
            sp_valid <= 1'b1;
            sp_data  <= sel_data;
            sp_last  <= sel_last;
            sp_src   <= grant;
        end
    end

    assign M_AXIS_TDATA  = m_data;
    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TLAST  = m_last;
    assign M_AXIS_TSRC   = m_src;

endmodule

// File: tb/tb_axi_rr_mux4.sv
// Bench for axi_rr_mux4: occupancy/queue reference model checked every cycle,
// directed packet scenarios with literal expectations, then a randomized phase.
module tb_axi_rr_mux4;

    localparam int         W    = 64;
    localparam logic [3:0] MASK = 4'b0011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_tdata  [4];
    logic         s_tvalid [4];
    logic         s_tlast  [4];
    logic         s_tready [4];
    logic [W-1:0] m_tdata;
    logic         m_tvalid, m_tlast, m_tready;
    logic [1:0]   m_tsrc;

    always #5 clk = ~clk;

    axi_rr_mux4 #(.C_AXIS_DATA_WIDTH(W), .C_ACTIVE_MASK(MASK)) dut (
        .clk(clk), .rst(rst),
        .S_AXIS_TDATA0(s_tdata[0]), .S_AXIS_TVALID0(s_tvalid[0]), .S_AXIS_TLAST0(s_tlast[0]), .S_AXIS_TREADY0(s_tready[0]),
        .S_AXIS_TDATA1(s_tdata[1]), .S_AXIS_TVALID1(s_tvalid[1]), .S_AXIS_TLAST1(s_tlast[1]), .S_AXIS_TREADY1(s_tready[1]),
        .S_AXIS_TDATA2(s_tdata[2]), .S_AXIS_TVALID2(s_tvalid[2]), .S_AXIS_TLAST2(s_tlast[2]), .S_AXIS_TREADY2(s_tready[2]),
        .S_AXIS_TDATA3(s_tdata[3]), .S_AXIS_TVALID3(s_tvalid[3]), .S_AXIS_TLAST3(s_tlast[3]), .S_AXIS_TREADY3(s_tready[3]),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TREADY(m_tready), .M_AXIS_TSRC(m_tsrc)
    );

    typedef struct { logic [W-1:0] d; logic l; logic [1:0] s; } beat_t;
    typedef struct { logic [W-1:0] d; logic l; logic [1:0] s; int cyc; } log_t;

    beat_t q[$];        // beats the model says are held in the output buffer
    log_t  mlog[$];     // every beat transferred on M
    int    cur    = -1; // input currently owning the output, -1 between packets
    int    last_g = 3;
    int    cyc    = 0;
    bit    chk_en = 0;
    int    checks = 0;
    int    errors = 0;
    int    tr2_cnt = 0;
    int    aa_seen = 0;
    int    done_cnt = 0;
    int    tot = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int lg);
        for (int k = 1; k <= 4; k++) begin
            if (r[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [3:0] req;
        bit         exp_rdy [4];
        bit         acc, drain;
        beat_t      b;
        log_t       e;
        cyc++;
        for (int i = 0; i < 4; i++) exp_rdy[i] = (cur == i) && (q.size() < 2);
        if (chk_en) begin
            chk("m_tvalid", m_tvalid, q.size() > 0);
            if (q.size() > 0) begin
                chk("m_tdata", m_tdata, q[0].d);
                chk("m_tlast", m_tlast, q[0].l);
                chk("m_tsrc",  m_tsrc,  q[0].s);
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("s_tready%0d", i), s_tready[i], exp_rdy[i]);
            if (s_tready[2]) tr2_cnt++;
            if (m_tvalid && m_tdata == 64'hAA) aa_seen++;
        end
        if (m_tvalid && m_tready && !rst) begin
            e.d = m_tdata; e.l = m_tlast; e.s = m_tsrc; e.cyc = cyc;
            mlog.push_back(e);
        end
        if (rst) begin
            q.delete();
            cur    = -1;
            last_g = 3;
        end else begin
            drain = (q.size() > 0) && m_tready;
            acc   = 0;
            if (cur < 0) begin
                req = {s_tvalid[3], s_tvalid[2], s_tvalid[1], s_tvalid[0]} & MASK;
                if (req != 4'b0) cur = rr_pick(req, last_g);
            end else if (s_tvalid[cur] && exp_rdy[cur]) begin
                acc = 1;
                b.d = s_tdata[cur]; b.l = s_tlast[cur]; b.s = 2'(cur);
            end
            if (drain) void'(q.pop_front());
            if (acc) begin
                q.push_back(b);
                if (b.l) begin
                    last_g = cur;
                    cur    = -1;
                end
            end
        end
    end

    task automatic wait_hs(input int i);
        int n  = 0;
        bit hs = 0;
        while (!hs && n < 1000) begin
            @(negedge clk);
            hs = s_tvalid[i] && s_tready[i];
            @(posedge clk); #1;
            n++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL handshake_timeout input %0d: no accept after %0d cycles, accept required", i, n);
        end
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (mlog.size() < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (mlog.size() < n) begin
            checks++; errors++;
            $display("FAIL output_timeout: %0d beats on M, %0d required", mlog.size(), n);
        end
    endtask

    task automatic send_pkt(input int i, input int len, input logic [W-1:0] base,
                            input int gap_pct, input int drop_at);
        for (int b = 0; b < len; b++) begin
            if (b == drop_at) begin
                s_tvalid[i] = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            while ($urandom_range(99) < gap_pct) begin
                s_tvalid[i] = 1'b0;
                @(posedge clk); #1;
            end
            s_tdata[i]  = base + W'(b);
            s_tlast[i]  = (b == len - 1);
            s_tvalid[i] = 1'b1;
            wait_hs(i);
        end
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    initial begin
        int base, n, pk;
        bit start;
        logic [W-1:0] exp1 [6];
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0;
        end
        m_tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk_en = 1;
        rst    = 1'b0;

        @(negedge clk);
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_m_tlast",  m_tlast,  0);
        chk("reset_m_tsrc",   m_tsrc,   0);
        for (int i = 0; i < 4; i++) chk($sformatf("reset_s_tready%0d", i), s_tready[i], 0);
        @(posedge clk); #1;

        // two simultaneous 3-beat packets, plus masked input 2 holding 0xAA
        s_tdata[2] = 64'hAA; s_tlast[2] = 1'b1; s_tvalid[2] = 1'b1;
        exp1[0] = 'h100; exp1[1] = 'h101; exp1[2] = 'h102;
        exp1[3] = 'h200; exp1[4] = 'h201; exp1[5] = 'h202;
        base = mlog.size();
        fork
            send_pkt(0, 3, 'h100, 0, -1);
            send_pkt(1, 3, 'h200, 0, -1);
        join
        wait_log(base + 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_data%0d", k), mlog[base+k].d, exp1[k]);
            chk($sformatf("t1_src%0d", k),  mlog[base+k].s, (k < 3) ? 0 : 1);
            chk($sformatf("t1_last%0d", k), mlog[base+k].l, (k == 2 || k == 5));
        end
        chk("t1_bubble_gap", mlog[base+3].cyc - mlog[base+2].cyc, 2);

        // input 0 back-to-back 2-beat packets vs input 1 continuous
        base = mlog.size();
        fork
            begin for (int p = 0; p < 4; p++) send_pkt(0, 2, 'h300 + 16*p, 0, -1); end
            begin for (int p = 0; p < 4; p++) send_pkt(1, 3, 'h400 + 16*p, 0, -1); end
        join
        wait_log(base + 20);
        pk = 0; start = 1;
        for (int k = base; k < base + 20; k++) begin
            if (start) begin
                chk($sformatf("t2_pkt%0d_src", pk), mlog[k].s, pk % 2);
                pk++;
            end
            start = mlog[k].l;
        end
        chk("t2_pkt_count", pk, 8);

        // downstream stall for 5 cycles mid-packet
        base = mlog.size();
        fork
            send_pkt(0, 8, 'h10, 0, -1);
            begin
                wait_log(base + 3);
                m_tready = 1'b0;
                n = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (s_tready[0]) n++;
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
                chk("t3_tready0_during_stall", n, 1);
            end
        join
        wait_log(base + 8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_data%0d", k), mlog[base+k].d, 'h10 + k);

        // granted input pauses 3 cycles mid-packet while input 1 waits
        base = mlog.size();
        fork
            send_pkt(0, 4, 'h500, 0, 2);
            begin
                repeat (2) begin @(posedge clk); #1; end
                send_pkt(1, 2, 'h600, 0, -1);
            end
        join
        wait_log(base + 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t5_src%0d", k), mlog[base+k].s, (k < 4) ? 0 : 1);
        chk("t5_first_in1_data", mlog[base+4].d, 'h600);

        // reset during beat 2 of a 4-beat packet
        base = mlog.size();
        send_pkt(0, 1, 'h50, 0, -1);
        wait_log(base + 1);
        s_tdata[0] = 'h60; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
        wait_hs(0);
        s_tdata[0] = 'h61;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        chk("t6_m_tvalid_after_rst", m_tvalid, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_s_tready%0d_after_rst", i), s_tready[i], 0);
        @(posedge clk); #1;
        base = mlog.size();
        fork
            send_pkt(0, 2, 'h70, 0, -1);
            send_pkt(1, 2, 'h80, 0, -1);
        join
        wait_log(base + 4);
        chk("t6_first_src", mlog[base].s, 0);
        chk("t6_first_data", mlog[base].d, 'h70);
        chk("t6_second_pkt_src", mlog[base+2].s, 1);

        // randomized traffic with gaps, pauses and downstream backpressure
        base = mlog.size();
        tot = 0;
        done_cnt = 0;
        s_tdata[3] = 64'hAA; s_tlast[3] = 1'b1;
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    n = $urandom_range(4, 1);
                    tot += n;
                    send_pkt(0, n, 'h1000 + 16*p, 25, ($urandom_range(3) == 0) ? 1 : -1);
                    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                end
                done_cnt++;
            end
            begin
                for (int p = 0; p < 25; p++) begin
                    int len1;
                    len1 = $urandom_range(4, 1);
                    tot += len1;
                    send_pkt(1, len1, 'h2000 + 16*p, 25, -1);
                    repeat ($urandom_range(2)) begin @(posedge clk); #1; end
                end
                done_cnt++;
            end
            begin
                while (done_cnt < 2) begin
                    s_tvalid[2] = 1'($urandom_range(1));
                    s_tvalid[3] = 1'($urandom_range(1));
                    @(posedge clk); #1;
                end
                s_tvalid[2] = 1'b0;
                s_tvalid[3] = 1'b0;
            end
            begin
                while (done_cnt < 2) begin
                    m_tready = ($urandom_range(99) < 65);
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
            end
        join
        repeat (10) begin @(posedge clk); #1; end
        chk("rand_beats_out", mlog.size() - base, tot);
        chk("masked_tready2_count", tr2_cnt, 0);
        chk("masked_data_seen", aa_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
